// File: rtl/exec_unit_mc.sv
// Multi-cycle execute unit: single-cycle LOAD/ADD/SUB (+immediate forms) and a
// DATA_W-iteration shift-add multiplier, with valid/ready handshakes on both sides.
module exec_unit_mc #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 7,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] rg2,
  input  logic [DATA_W-1:0] rg3,
  input  logic [IMM_W-1:0]  imm,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] d1,
  output logic [TAG_W-1:0]  tag_out,
  output logic              wr_en,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              err
);

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SUBI = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_MULI = 3'd6;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TAG_W-1:0]    mul_tag_q;
  logic                out_valid_q, z_q, n_q, v_q, err_q;
  logic [DATA_W-1:0]   d1_q;
  logic [TAG_W-1:0]    tag_q;

  logic [DATA_W-1:0]   mag, immx, opb, sum, diff, acc_d;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_v, alu_err, accept, is_mul;

  // Sign-magnitude immediate; a negated zero magnitude is still zero.
  assign mag  = {{(DATA_W-IMM_W+1){1'b0}}, imm[IMM_W-2:0]};
  assign immx = imm[IMM_W-1] ? (~mag + 1'b1) : mag;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (opcode == OP_MUL) || (opcode == OP_MULI);

  assign opb   = ((opcode == OP_ADD) || (opcode == OP_SUB)) ? rg3 : immx;
  assign sum   = rg2 + opb;
  assign diff  = rg2 - opb;
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      OP_LOAD: alu_res = immx;
      OP_ADD, OP_ADDI: begin
        alu_res = sum;
        alu_v   = (rg2[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != rg2[DATA_W-1]);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = diff;
        alu_v   = (rg2[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != rg2[DATA_W-1]);
      end
      default: alu_err = !is_mul;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_tag_q   <= '0;
      out_valid_q <= 1'b0;
      d1_q        <= '0;
      tag_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_mul) begin
            mcand_q     <= rg2;
            mplier_q    <= (opcode == OP_MUL) ? rg3 : immx;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_tag_q   <= tag_in;
            out_valid_q <= 1'b0;
            state_q     <= S_MUL;
          end else if (accept) begin
            d1_q        <= alu_res;
            tag_q       <= tag_in;
            z_q         <= (alu_res == '0);
            n_q         <= alu_res[DATA_W-1];
            v_q         <= alu_v;
            err_q       <= alu_err;
            out_valid_q <= 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            d1_q        <= acc_d;
            tag_q       <= mul_tag_q;
            z_q         <= (acc_d == '0);
            n_q         <= acc_d[DATA_W-1];
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign d1        = d1_q;
  assign tag_out   = tag_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;
  assign err       = err_q;
  assign wr_en     = out_valid_q && !err_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: each task drives one scenario and checks
// hand-computed results inline.
module tb_exec_unit_mc;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  opcode, tag_in, tag_out;
  logic [15:0] rg2, rg3, d1;
  logic [6:0]  imm;
  logic        wr_en, flag_z, flag_n, flag_v, err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exec_unit_mc #(.DATA_W(16), .IMM_W(7), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rg2(rg2), .rg3(rg3), .imm(imm), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .d1(d1), .tag_out(tag_out),
    .wr_en(wr_en), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [6:0] im, input logic [2:0] t);
    opcode = op; rg2 = a; rg3 = b; imm = im; tag_in = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 3'd0; rg2 = '0; rg3 = '0; imm = '0; tag_in = '0;
    tick(); tick();
    vectors++; if ({out_valid, d1, tag_out, flag_z, flag_n, flag_v, err} !== 23'd0) begin
      miscompares++; $display("FAIL reset_outputs got ov=%b d1=%h tag=%0d z%b n%b v%b err=%b required all 0",
        out_valid, d1, tag_out, flag_z, flag_n, flag_v, err); end
    rst_n = 1'b1;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    $display("reset: ov=%b d1=%h in_ready=%b", out_valid, d1, in_ready);
  endtask

  task automatic test_load();
    issue(3'd0, 16'h0, 16'h0, 7'b1000101, 3'd3);
    $display("LOAD -5 tag3: d1=%h tag=%0d n=%b wr_en=%b", d1, tag_out, flag_n, wr_en);
    vectors++; if ({out_valid, d1, tag_out, flag_n, flag_z, wr_en} !== {1'b1, 16'hFFFB, 3'd3, 1'b1, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL load_neg got ov=%b d1=%h tag=%0d n=%b z=%b wr=%b required 1 fffb 3 1 0 1",
        out_valid, d1, tag_out, flag_n, flag_z, wr_en); end
    issue(3'd0, 16'h0, 16'h0, 7'b1000000, 3'd1);
    $display("LOAD -0: d1=%h z=%b", d1, flag_z);
    vectors++; if ({out_valid, d1, flag_z, flag_n} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL load_negzero got ov=%b d1=%h z=%b n=%b required 1 0000 1 0",
        out_valid, d1, flag_z, flag_n); end
    tick();
    vectors++; if ({out_valid, d1} !== {1'b0, 16'h0000}) begin
      miscompares++; $display("FAIL retire_hold got ov=%b d1=%h required 0 0000", out_valid, d1); end
  endtask

  task automatic test_add_sub();
    issue(3'd1, 16'h7FFF, 16'h0001, 7'd0, 3'd2);
    $display("ADD 7fff+1: d1=%h v=%b n=%b", d1, flag_v, flag_n);
    vectors++; if ({d1, flag_v, flag_n, flag_z} !== {16'h8000, 1'b1, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL add_ovf got d1=%h v=%b n=%b z=%b required 8000 1 1 0", d1, flag_v, flag_n, flag_z); end
    issue(3'd4, 16'd10, 16'h0, 7'b1000011, 3'd4);
    $display("SUBI 10-(-3): d1=%h v=%b", d1, flag_v);
    vectors++; if ({d1, flag_v, flag_n, tag_out} !== {16'd13, 1'b0, 1'b0, 3'd4}) begin
      miscompares++; $display("FAIL subi got d1=%h v=%b n=%b tag=%0d required 000d 0 0 4", d1, flag_v, flag_n, tag_out); end
    issue(3'd3, 16'h8000, 16'h0001, 7'd0, 3'd0);
    $display("SUB 8000-1: d1=%h v=%b", d1, flag_v);
    vectors++; if ({d1, flag_v, flag_n} !== {16'h7FFF, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL sub_ovf got d1=%h v=%b n=%b required 7fff 1 0", d1, flag_v, flag_n); end
    issue(3'd2, 16'd5, 16'hFFFF, 7'b0000011, 3'd0);
    $display("ADDI 5+3: d1=%h", d1);
    vectors++; if ({d1, flag_v} !== {16'd8, 1'b0}) begin
      miscompares++; $display("FAIL addi got d1=%h v=%b required 0008 0", d1, flag_v); end
    tick();
  endtask

  task automatic test_mul();
    int lat;
    logic busy_ok;
    issue(3'd6, 16'hFFFD, 16'h0, 7'b0000111, 3'd2);
    // Junk request held during the busy period must be ignored.
    opcode = 3'd1; rg2 = 16'h1111; rg3 = 16'h2222; imm = 7'h7F; tag_in = 3'd7; in_valid = 1'b1;
    lat = 0; busy_ok = (in_ready === 1'b0) && (out_valid === 1'b0);
    for (int k = 1; k <= 40; k++) begin
      if (k == 15) in_valid = 1'b0;
      tick();
      if (out_valid === 1'b1) begin lat = k; break; end
      if (in_ready !== 1'b0) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
    $display("MULI fffd*7: latency=%0d d1=%h tag=%0d", lat, d1, tag_out);
    vectors++; if (busy_ok !== 1'b1) begin miscompares++; $display("FAIL mul_busy got in_ready high while busy required 0"); end
    vectors++; if (lat != 16) begin miscompares++; $display("FAIL mul_latency got %0d required 16", lat); end
    vectors++; if ({d1, flag_v, flag_n, tag_out, wr_en, in_ready} !== {16'hFFEB, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL muli_result got d1=%h v=%b n=%b tag=%0d wr=%b rdy=%b required ffeb 0 1 2 1 0",
        d1, flag_v, flag_n, tag_out, wr_en, in_ready); end
    tick();
    vectors++; if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL mul_retire got ov=%b rdy=%b required 0 1", out_valid, in_ready); end
    issue(3'd5, 16'd300, 16'd300, 7'd0, 3'd6);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    $display("MUL 300*300: latency=%0d d1=%h", lat, d1);
    vectors++; if ({lat == 16, d1, tag_out} !== {1'b1, 16'h5F90, 3'd6}) begin
      miscompares++; $display("FAIL mul_300 got lat=%0d d1=%h tag=%0d required 16 5f90 6", lat, d1, tag_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic hold_ok;
    out_ready = 1'b0;
    issue(3'd1, 16'd2, 16'd3, 7'd0, 3'd1);
    opcode = 3'd3; rg2 = 16'd9; rg3 = 16'd4; tag_in = 3'd6; in_valid = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if ({out_valid, d1, tag_out, in_ready} !== {1'b1, 16'd5, 3'd1, 1'b0}) hold_ok = 1'b0;
      tick();
    end
    $display("ADD 2+3 under back-pressure: d1=%h tag=%0d rdy=%b", d1, tag_out, in_ready);
    vectors++; if (hold_ok !== 1'b1 || d1 !== 16'd5 || tag_out !== 3'd1) begin
      miscompares++; $display("FAIL bp_hold got d1=%h tag=%0d required 0005 1 stable", d1, tag_out); end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    $display("SUB 9-4 back-to-back: d1=%h tag=%0d ov=%b", d1, tag_out, out_valid);
    vectors++; if ({out_valid, d1, tag_out} !== {1'b1, 16'd5, 3'd6}) begin
      miscompares++; $display("FAIL b2b got ov=%b d1=%h tag=%0d required 1 0005 6", out_valid, d1, tag_out); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    logic quiet;
    issue(3'd5, 16'd3, 16'd5, 7'd0, 3'd3);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("reset at mul iteration 7: ov=%b rdy=%b d1=%h", out_valid, in_ready, d1);
    vectors++; if ({out_valid, in_ready, d1} !== {1'b0, 1'b1, 16'h0000}) begin
      miscompares++; $display("FAIL mid_mul_reset got ov=%b rdy=%b d1=%h required 0 1 0000", out_valid, in_ready, d1); end
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      tick();
    end
    vectors++; if (quiet !== 1'b1) begin miscompares++; $display("FAIL mul_discard got out_valid after reset required 0"); end
    issue(3'd1, 16'd1, 16'd1, 7'd0, 3'd0);
    $display("ADD 1+1 after reset: d1=%h", d1);
    vectors++; if ({out_valid, d1} !== {1'b1, 16'd2}) begin
      miscompares++; $display("FAIL post_reset_add got ov=%b d1=%h required 1 0002", out_valid, d1); end
    tick();
  endtask

  task automatic test_reserved();
    issue(3'd7, 16'h1234, 16'h5678, 7'h15, 3'd5);
    $display("opcode 7 tag5: d1=%h err=%b wr_en=%b z=%b", d1, err, wr_en, flag_z);
    vectors++; if ({out_valid, d1, err, wr_en, flag_z, tag_out} !== {1'b1, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5}) begin
      miscompares++; $display("FAIL reserved got ov=%b d1=%h err=%b wr=%b z=%b tag=%0d required 1 0000 1 0 1 5",
        out_valid, d1, err, wr_en, flag_z, tag_out); end
    issue(3'd1, 16'd4, 16'd4, 7'd0, 3'd2);
    $display("ADD 4+4 after err: d1=%h err=%b wr_en=%b", d1, err, wr_en);
    vectors++; if ({d1, err, wr_en} !== {16'd8, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL err_clear got d1=%h err=%b wr=%b required 0008 0 1", d1, err, wr_en); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_reserved();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Parametrised, multi-cycle execute unit for the CPU datapath.
- Successor to the single-cycle 16-bit ALU. Supports configurable data width and immediate width.
- Adds valid/ready handshaking, a destination-register tag, status flags, and an iterative shift-add multiplier.
- Sits between decode (operand read) and register-file writeback.

Parameters:
- DATA_W, 16, operand/result width (>=8)
- IMM_W, 7, immediate width; sign-magnitude (MSB = sign, low IMM_W-1 bits = magnitude)
- TAG_W, 3, destination-register tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request this cycle
- opcode  in  3  0 LOAD, 1 ADD, 2 ADDI, 3 SUB, 4 SUBI, 5 MUL, 6 MULI, 7 reserved
- rg2  in  DATA_W  source operand A
- rg3  in  DATA_W  source operand B
- imm  in  IMM_W  sign-magnitude immediate
- tag_in  in  TAG_W  destination register tag
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts result
- d1  out  DATA_W  result
- tag_out  out  TAG_W  tag of the result
- wr_en  out  1  register-file write enable; equals out_valid & ~err
- flag_z  out  1  d1 == 0
- flag_n  out  1  d1[DATA_W-1]
- flag_v  out  1  signed overflow (ADD/ADDI/SUB/SUBI only; 0 otherwise)
- err  out  1  reserved opcode executed

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; out_valid, d1, tag_out, all flags and err = 0. Any multiply in progress is aborted and its result is discarded.
- Immediate conversion (combinational): mag = imm[IMM_W-2:0] zero-extended to DATA_W. immx = imm[IMM_W-1] ? -mag : mag. Negative zero yields 0.
- Accept: handshake = in_valid & in_ready at an edge.
- in_ready = (state==IDLE) & (~out_valid | out_ready).
- States:
  - IDLE: on accept of opcode 0-4 or 7, compute the result and register it into d1/flags/tag_out; out_valid=1 on the next cycle (latency 1); stay IDLE. On accept of MUL/MULI, latch multiplicand=rg2 and multiplier=(MUL ? rg3 : immx); clear accumulator; cnt=0; go to MUL.
  - MUL: each edge, if the multiplier LSB is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++. Arithmetic is mod 2^DATA_W, so the result is the low DATA_W bits of the two's-complement product. Unsigned and signed interpretations agree. On the edge where cnt reaches DATA_W-1 (the DATA_W-th iteration), write the final acc to d1, set out_valid=1, and go to DONE. Latency is DATA_W cycles from the accepting edge.
  - DONE: the result is pending. On the edge where out_ready=1, go to IDLE. in_ready=0 while in DONE.
- Results:
  - LOAD: d1 = immx.
  - ADD: d1 = rg2 + rg3.
  - ADDI: d1 = rg2 + immx.
  - SUB: d1 = rg2 - rg3.
  - SUBI: d1 = rg2 - immx.
  - MUL/MULI: as above.
  - 7: d1=0, err=1, flag_z=1, wr_en=0.
- flag_v: ADD/ADDI set it when operand signs are equal and the result sign differs. SUB/SUBI set it when operand signs differ and the result sign differs from rg2.
- Output hold: while out_valid=1 and out_ready=0, d1/tag_out/flags/err are stable.
- Output retire:
  - On an edge with out_valid & out_ready and no new accept, out_valid goes to 0 and outputs hold their last values.
  - If a 1-cycle op is accepted on the same edge, the new result replaces the old one and out_valid stays 1, giving back-to-back throughput of 1/cycle.
- Inputs are ignored whenever in_ready=0, including all opcode, operand, immediate and tag changes during MUL.

Test Plan:
- LOAD imm=7'b1000101, tag 3 -> next cycle d1=16'hFFFB, tag_out=3, flag_n=1, wr_en=1. Then LOAD imm=7'b1000000 -> d1=0, flag_z=1.
- ADD rg2=16'h7FFF, rg3=16'h0001 -> d1=16'h8000, flag_v=1, flag_n=1. Then SUBI rg2=10, imm=7'b1000011 -> d1=13, flag_v=0.
- MULI rg2=16'hFFFD, imm=7'b0000111 -> in_ready=0 for the busy cycles; out_valid rises exactly 16 cycles after accept with d1=16'hFFEB, flag_v=0. MUL 300*300 -> d1=16'h5F90.
- Back-pressure: ADD 2+3 with out_ready=0 for 5 cycles -> d1=5 held, in_ready=0. Raise out_ready with a pending in_valid SUB 9-4 -> next cycle d1=5 (new), out_valid stays 1.
- Reset mid-multiply: rst_n=0 at iteration 7 of a MUL -> next cycle out_valid=0, in_ready=1, d1=0. A following ADD 1+1 yields d1=2 one cycle later.
- Opcode 7 with tag 5 -> d1=0, err=1, wr_en=0, out_valid=1. Next accepted ADD clears err.
